seg7_decoder_rx: RTL and testbench
==================================

# seg7_decoder_rx

Receive-side counterpart of the seven-segment driver: samples a 7-bit segment bus (a=bit0 … g=bit6), filters glitches, decodes each stable pattern back to a hex digit and queues it for a consumer over a valid/ready interface. Used as an on-chip loopback checker behind the segment outputs of the TinyTapeout top level, and as a capture block for off-chip displays driven into `uio_in`.

## Interface
- `STABLE_CYCLES`, 4: cycles a pattern must hold after synchronisation before commit; legal 1..255.
- `ACTIVE_LOW`, 0: 1 = segment lit when input bit is 0; inversion applied before the synchroniser.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous flush: empties FIFO, clears `ovf` and `ev_cnt`, sets committed pattern to blank.
- `seg_in`  in  7  asynchronous segment bus, a=bit0 … g=bit6.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head entry.
- `out_digit`  out  4  head entry digit; 0 when `out_err`=1.
- `out_err`  out  1  head entry was an undecodable pattern.
- `ovf`  out  1  sticky: a commit was dropped because the FIFO was full.
- `ev_cnt`  out  8  committed events (pushed or dropped), wraps 255→0.

## Operation
- Input path: `seg_in` (inverted if `ACTIVE_LOW`) → `s1` → `s2` (2-flop synchroniser) → `s3` (previous `s2`).
- Stability counter `cnt` (8 bit): `s2`≠`s3` → 0; else increment, saturating at `STABLE_CYCLES`.
- Commit strobe: `cnt`==`STABLE_CYCLES`-1, `s2`==`s3`, `s2`≠committed pattern. On the edge it fires: committed ← `s2`.
- Blank (`s2`==0x00): committed updated, nothing pushed, `ev_cnt` unchanged. A repeated digit therefore yields a second event only if separated by blank or another pattern.
- Non-blank commit: push {err, digit}; `ev_cnt`+1.
- Decode (exact match only): 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F A=0x77 b=0x7C C=0x39 d=0x5E E=0x79 F=0x71; any other non-blank → err=1, digit=0.
- FIFO: 4 entries × 5 bits, first-word fall-through; pop when `out_valid`&&`out_ready`.
- Full and push with no pop: entry dropped, `ovf`←1, `ev_cnt` still increments. Full with simultaneous push and pop: both occur, no overflow.
- Empty with push: entry visible on outputs the cycle after the push edge; no bypass.
- `clr` has priority over push/pop in the same cycle; synchroniser and `cnt` not cleared.

## Timing
- Reset values: `out_valid`=0, `out_digit`=0, `out_err`=0, `ovf`=0, `ev_cnt`=0; `s1`/`s2`/`s3`/committed=0x00 (blank), `cnt`=0, FIFO empty.
- Latency: `seg_in` changed before edge 1 and held → push at edge `STABLE_CYCLES`+3 → `out_valid` high after that edge (7 edges for default).
- Any pattern change before commit restarts the count; glitches shorter than `STABLE_CYCLES`+1 synchronised cycles never commit.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight entries lost.
- Throughput: at most one commit per `STABLE_CYCLES`+1 cycles; one pop per cycle.

## Structure
- Package `seg7_pkg`: `SEG_0`..`SEG_F`, `SEG_BLANK` 7-bit constants; `seg7_decode` function returning {err, digit}; shared with the driver so encode and decode tables cannot diverge.
- Sub-module `seg7_fifo` (parameterised width/depth, FWFT, full/empty, push/pop/flush); decoder top holds synchroniser, stability counter, commit logic, `ev_cnt`, `ovf`.

## Test plan
- Reset, then `seg_in`=0x5B held, `out_ready`=1 → `out_valid` high exactly after edge 7, `out_digit`=2, `out_err`=0, `ev_cnt`=1.
- 0x06 held 3 cycles then 0x4F held → only digit 3 emitted; no entry for 1.
- `out_ready`=0, apply 0x3F,0x06,0x5B,0x4F,0x66 each stable 10 cycles → 4 entries 0,1,2,3 retained, `ovf`=1, `ev_cnt`=5; then drain → 0,1,2,3 in order.
- 0x77, blank, 0x77 → two A entries; 0x77 held 100 cycles → one entry. Pattern 0x01 → `out_err`=1, `out_digit`=0.
- `ACTIVE_LOW`=1, `seg_in`=0x40 (inverted 0x3F) → digit 0; full FIFO with push and pop same cycle → no `ovf`.
- `rst_n` pulsed low during stability count, and `clr` with full FIFO → all outputs 0, next commit behaves as first after reset.

Source files
------------

// File: rtl/seg7_pkg.sv
// Seven-segment code tables and decoder, shared by the segment driver and receiver.
// Latency: combinational helpers only.
// Backpressure: not applicable (no ports).
// Segment order in every constant: a=bit0 ... g=bit6, 1 = segment lit.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;

  // Receive queue depth (entries).
  localparam int unsigned FIFO_DEPTH = 4;

  // One decoded display event: err=1 means the pattern matched no digit.
  typedef struct packed {
    logic       err;
    logic [3:0] digit;
  } seg7_dec_t;

  // Exact-match decode; anything unlisted (blank included) is an error with digit 0.
  function automatic seg7_dec_t seg7_decode(input logic [6:0] seg);
    seg7_dec_t r;
    r = '0;
    case (seg)
      SEG_0:   r.digit = 4'h0;
      SEG_1:   r.digit = 4'h1;
      SEG_2:   r.digit = 4'h2;
      SEG_3:   r.digit = 4'h3;
      SEG_4:   r.digit = 4'h4;
      SEG_5:   r.digit = 4'h5;
      SEG_6:   r.digit = 4'h6;
      SEG_7:   r.digit = 4'h7;
      SEG_8:   r.digit = 4'h8;
      SEG_9:   r.digit = 4'h9;
      SEG_A:   r.digit = 4'hA;
      SEG_B:   r.digit = 4'hB;
      SEG_C:   r.digit = 4'hC;
      SEG_D:   r.digit = 4'hD;
      SEG_E:   r.digit = 4'hE;
      SEG_F:   r.digit = 4'hF;
      default: r.err   = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_fifo.sv
// Generic first-word-fall-through FIFO with synchronous flush.
// Latency: a push is visible on rdata_o/empty_o the cycle after the push edge (no bypass).
// Backpressure: push while full is dropped unless a pop happens on the same edge; pop while empty ignored.
// Ports: clk_i, rst_n_i (async, active low), flush_i (wins over push/pop),
//        push_i/wdata_i, pop_i, rdata_o (head entry), empty_o, full_o.
module seg7_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4   // power of two: pointers wrap naturally
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DEPTH_C);
  assign rdata_o = mem_q[rd_q];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/seg7_decoder_rx.sv
// Seven-segment receiver: synchronise, deglitch, decode each stable pattern and queue it.
// Latency: pattern applied before edge 1 and held is pushed at edge STABLE_CYCLES+3, visible after it.
// Backpressure: valid/ready output; when the 4-entry queue is full new events are dropped and ovf_o sticks.
// Ports: clk_i, rst_n_i (async, active low), clr_i (sync flush), seg_i (async bus, a=bit0..g=bit6),
//        out_valid_o/out_ready_i/out_digit_o/out_err_o (head entry), ovf_o, ev_cnt_o.
module seg7_decoder_rx
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,    // legal 1..255
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       clr_i,
  input  logic [6:0] seg_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [3:0] out_digit_o,
  output logic       out_err_o,
  output logic       ovf_o,
  output logic [7:0] ev_cnt_o
);

  localparam logic [7:0] STABLE_C  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

  logic [6:0] seg_pol;
  logic [6:0] s1_q, s2_q, s3_q;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] comm_q, comm_d;
  logic [7:0] ev_q, ev_d;
  logic       ovf_q, ovf_d;
  logic       commit, push, pop;
  logic       fifo_empty, fifo_full;
  seg7_dec_t  dec;
  logic [4:0] head_raw;
  seg7_dec_t  head;

  // Polarity is normalised before the synchroniser so everything downstream sees lit=1.
  assign seg_pol = ACTIVE_LOW ? ~seg_i : seg_i;

  // Counter restarts on every change of the synchronised pattern and parks at STABLE_CYCLES,
  // so a pattern held indefinitely commits only once.
  always_comb begin
    cnt_d = cnt_q;
    if (s2_q != s3_q)           cnt_d = '0;
    else if (cnt_q != STABLE_C) cnt_d = cnt_q + 8'd1;
  end

  assign commit = (cnt_q == STABLE_M1) && (s2_q == s3_q) && (s2_q != comm_q);

  // Blank commits only re-arm the committed pattern; they never produce an event.
  assign push = commit && !clr_i && (s2_q != SEG_BLANK);
  assign pop  = out_ready_i && !fifo_empty;
  assign dec  = seg7_decode(s2_q);

  always_comb begin
    comm_d = comm_q;
    ev_d   = ev_q;
    ovf_d  = ovf_q;
    if (clr_i) begin
      comm_d = SEG_BLANK;
      ev_d   = '0;
      ovf_d  = 1'b0;
    end else begin
      if (commit) comm_d = s2_q;
      if (push) begin
        ev_d = ev_q + 8'd1;   // dropped events still count
        if (fifo_full && !pop) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q   <= SEG_BLANK;
      s2_q   <= SEG_BLANK;
      s3_q   <= SEG_BLANK;
      cnt_q  <= '0;
      comm_q <= SEG_BLANK;
      ev_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      s1_q   <= seg_pol;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      cnt_q  <= cnt_d;
      comm_q <= comm_d;
      ev_q   <= ev_d;
      ovf_q  <= ovf_d;
    end
  end

  seg7_fifo #(
    .WIDTH ($bits(seg7_dec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (clr_i),
    .push_i  (push),
    .wdata_i (dec),
    .pop_i   (pop),
    .rdata_o (head_raw),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign head = seg7_dec_t'(head_raw);

  // Stale storage is masked so an empty queue always presents zeros.
  assign out_valid_o = !fifo_empty;
  assign out_digit_o = fifo_empty ? 4'h0 : head.digit;
  assign out_err_o   = fifo_empty ? 1'b0 : head.err;
  assign ovf_o       = ovf_q;
  assign ev_cnt_o    = ev_q;

endmodule

// File: tb/tb_seg7_decoder_rx.sv
module tb_seg7_decoder_rx;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n, clr, out_ready;
  logic [6:0] seg, seg_n;

  logic       a_valid, a_err, a_ovf;
  logic [3:0] a_digit;
  logic [7:0] a_ev;
  logic       b_valid, b_err, b_ovf;
  logic [3:0] b_digit;
  logic [7:0] b_ev;

  always #5 clk = ~clk;
  assign seg_n = ~seg;

  seg7_decoder_rx #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .seg_i(seg),
    .out_valid_o(a_valid), .out_ready_i(out_ready), .out_digit_o(a_digit),
    .out_err_o(a_err), .ovf_o(a_ovf), .ev_cnt_o(a_ev));

  // Same traffic on an inverted bus must give identical results.
  seg7_decoder_rx #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b1)) u_dut_lo (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .seg_i(seg_n),
    .out_valid_o(b_valid), .out_ready_i(out_ready), .out_digit_o(b_digit),
    .out_err_o(b_err), .ovf_o(b_ovf), .ev_cnt_o(b_ev));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [4:0] m_q [$];     // {err, digit}
  logic [6:0] hist [$];    // hist[0] = most recent sample of the bus
  logic [6:0] m_comm;
  logic       m_ovf;
  logic [7:0] m_ev;

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (codes[i] == p) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  task automatic model_reset();
    m_q.delete();
    hist.delete();
    repeat (S + 3) hist.push_back(7'h00);
    m_comm = 7'h00;
    m_ovf  = 1'b0;
    m_ev   = 8'h00;
  endtask

  // A pattern commits two edges after it has been sampled S+1 times in a row,
  // counted from its first appearance, provided it differs from the committed one.
  task automatic model_edge();
    logic [6:0] v;
    bit         run, popped;
    v   = hist[1];
    run = (hist[S+2] != v);
    for (int j = 0; j <= S; j++) if (hist[1+j] != v) run = 0;
    if (clr) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_ev   = 8'h00;
      m_comm = 7'h00;
    end else begin
      popped = (m_q.size() > 0) && out_ready;
      if (popped) void'(m_q.pop_front());
      if (run && v != m_comm) begin
        m_comm = v;
        if (v != 7'h00) begin
          m_ev = m_ev + 8'd1;
          if (m_q.size() < 4) m_q.push_back(ref_decode(v));
          else m_ovf = 1'b1;
        end
      end
    end
    hist.push_front(seg);
    void'(hist.pop_back());
  endtask

  task automatic check_outs();
    logic       ev_v, ev_e;
    logic [3:0] ev_d;
    ev_v = (m_q.size() > 0);
    ev_d = ev_v ? m_q[0][3:0] : 4'h0;
    ev_e = ev_v ? m_q[0][4]   : 1'b0;
    chk("valid_hi", a_valid, ev_v);
    chk("digit_hi", a_digit, ev_d);
    chk("err_hi",   a_err,   ev_e);
    chk("ovf_hi",   a_ovf,   m_ovf);
    chk("ev_hi",    a_ev,    m_ev);
    chk("valid_lo", b_valid, ev_v);
    chk("digit_lo", b_digit, ev_d);
    chk("err_lo",   b_err,   ev_e);
    chk("ovf_lo",   b_ovf,   m_ovf);
    chk("ev_lo",    b_ev,    m_ev);
  endtask

  // Inputs change only after the falling edge; outputs are checked there too.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_outs();
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg = p;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs();
    @(posedge clk);
    @(negedge clk);
    check_outs();
    rst_n = 1'b1;
  endtask

  logic [6:0] fill_pats [5] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66};

  initial begin
    rst_n = 1'b1; clr = 1'b0; out_ready = 1'b0; seg = 7'h00;
    #0 rst_n = 1'b0;
    do_reset();

    // First event latency: push at edge S+3.
    out_ready = 1'b1;
    seg = 7'h5B;
    repeat (S + 2) step();
    chk("lat_early", a_valid, 1'b0);
    step();
    chk("lat_valid", a_valid, 1'b1);
    chk("lat_digit", a_digit, 4'h2);
    chk("lat_ev", a_ev, 8'd1);
    hold(7'h5B, 5);

    // Short glitch of digit 1 must not commit.
    hold(7'h06, 3);
    hold(7'h4F, 10);
    chk("glitch_ev", a_ev, 8'd2);

    // Overflow: five events into four slots, then drain in order.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) hold(fill_pats[i], 10);
    chk("ovf_set", a_ovf, 1'b1);
    chk("ovf_ev", a_ev, 8'd5);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_digit", a_digit, 32'(i));
      step();
    end
    chk("drain_empty", a_valid, 1'b0);

    // Repeats need a blank in between; long hold gives one event; bad pattern flags err.
    do_reset();
    out_ready = 1'b0;
    hold(7'h77, 10);
    hold(7'h00, 10);
    hold(7'h77, 100);
    chk("rep_ev", a_ev, 8'd2);
    hold(7'h01, 10);
    out_ready = 1'b1;
    chk("rep_a0", a_digit, 4'hA);
    step();
    chk("rep_a1", a_digit, 4'hA);
    step();
    chk("bad_err", a_err, 1'b1);
    chk("bad_digit", a_digit, 4'h0);
    step();

    // Full queue with push and pop on the same edge: no overflow.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) hold(fill_pats[i], 10);
    seg = 7'h66;
    repeat (S + 2) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pp_ovf", a_ovf, 1'b0);
    chk("pp_ev", a_ev, 8'd5);
    chk("al_head", b_digit, 4'h1);

    // Overflow, then clr wipes queue, ovf and counter.
    hold(7'h77, 10);
    chk("pre_clr_ovf", a_ovf, 1'b1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_valid", a_valid, 1'b0);
    chk("clr_ovf", a_ovf, 1'b0);
    chk("clr_ev", a_ev, 8'd0);
    hold(7'h5B, 10);
    chk("post_clr_ev", a_ev, 8'd1);
    chk("post_clr_digit", a_digit, 4'h2);

    // Reset in the middle of a stability count.
    out_ready = 1'b1;
    seg = 7'h66;
    repeat (3) step();
    do_reset();
    hold(7'h66, 10);
    chk("post_rst_ev", a_ev, 8'd1);

    // Randomised traffic.
    for (int ph = 0; ph < 300; ph++) begin
      int r, len, thr;
      logic [6:0] p;
      if ($urandom_range(0, 49) == 0) do_reset();
      r = $urandom_range(0, 9);
      if (r < 5)       p = codes[$urandom_range(0, 15)];
      else if (r == 5) p = 7'h00;
      else             p = 7'($urandom);
      len = $urandom_range(1, 12);
      thr = $urandom_range(0, 10);
      seg = p;
      repeat (len) begin
        out_ready = ($urandom_range(0, 9) < thr);
        clr = ($urandom_range(0, 199) == 0);
        step();
      end
      clr = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
